reg_scoreboard: RTL and testbench

Write-side companion to the decode-stage register file. It tracks destination registers that are in flight between decode issue and writeback retirement. It raises a decode stall whenever a source register still has an unretired write. It also checks that the writeback port never retires a write that was not issued. It sits beside the register file: decode feeds it the read addresses and the issue request, and writeback feeds it the same write-enable and address that drive the register file's write port.

---
 rtl/reg_scoreboard.sv | 123 ++++++++++++
 tb/tb_reg_scoreboard.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Counts unretired destination writes per architectural register so decode can
// stall on a read-after-write hazard, and flags writeback retiring a register
// that has nothing outstanding. Register 0 is hardwired and never tracked.
module reg_scoreboard #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDRESS_WIDTH-1:0]           rs1,
  input  logic [ADDRESS_WIDTH-1:0]           rs2,
  input  logic                               use_rs1,
  input  logic                               use_rs2,
  input  logic                               issue_valid,
  input  logic                               issue_we,
  input  logic [ADDRESS_WIDTH-1:0]           issue_rd,
  input  logic                               wb_we,
  input  logic [ADDRESS_WIDTH-1:0]           wb_rd,
  output logic                               stall,
  output logic                               issue_fire,
  output logic [ADDRESS_WIDTH+CNT_WIDTH-1:0] inflight,
  output logic                               err_overflow,
  output logic                               err_underflow
);

  localparam int NumRegs  = 1 << ADDRESS_WIDTH;
  localparam int TotWidth = ADDRESS_WIDTH + CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [CNT_WIDTH-1:0] pend_q [NumRegs];
  logic [CNT_WIDTH-1:0] pend_d [NumRegs];
  logic [TotWidth-1:0]  inflight_q, inflight_d;
  logic                 errOverflow_q, errOverflow_d;
  logic                 errUnderflow_q, errUnderflow_d;

  logic                 src1Busy, src2Busy, retireSame, ovfBlock;
  logic [NumRegs-1:0]   incVec, decVec;
  logic                 incCounted, decCounted;

  // Hazard detection: a source with an outstanding write holds decode, and an
  // issue into a saturated counter is held unless that register retires now.
  // A same-cycle retire deliberately does not release a source stall, since the
  // register file only takes the new value at the clock edge.
  always_comb begin
    src1Busy   = use_rs1 && (rs1 != '0) && (pend_q[rs1] != '0);
    src2Busy   = use_rs2 && (rs2 != '0) && (pend_q[rs2] != '0);
    retireSame = wb_we && (wb_rd == issue_rd);
    ovfBlock   = issue_valid && issue_we && (issue_rd != '0) &&
                 (pend_q[issue_rd] == CntMax) && !retireSame;
    stall      = src1Busy || src2Busy || ovfBlock;
    issue_fire = issue_valid && !stall;
  end

  // One-hot increment/decrement requests; bit 0 is masked so register 0 is
  // never counted and never raises an error.
  always_comb begin
    incVec = '0;
    decVec = '0;
    if (issue_fire && issue_we) begin
      incVec = NumRegs'(1) << issue_rd;
    end
    if (wb_we) begin
      decVec = NumRegs'(1) << wb_rd;
    end
    incVec[0] = 1'b0;
    decVec[0] = 1'b0;
  end

  // Per-register counter update and error detection. An increment and a
  // decrement to the same register cancel; the total only moves for counted
  // events, so it tracks the sum of the counters exactly and cannot wrap.
  always_comb begin
    pend_d         = pend_q;
    errOverflow_d  = errOverflow_q;
    errUnderflow_d = errUnderflow_q;
    incCounted     = 1'b0;
    decCounted     = 1'b0;
    for (int r = 0; r < NumRegs; r++) begin
      if (incVec[r] && decVec[r]) begin
        pend_d[r] = pend_q[r];
      end else if (incVec[r]) begin
        if (pend_q[r] == CntMax) begin
          errOverflow_d = 1'b1;
        end else begin
          pend_d[r]  = pend_q[r] + 1'b1;
          incCounted = 1'b1;
        end
      end else if (decVec[r]) begin
        if (pend_q[r] == '0) begin
          errUnderflow_d = 1'b1;
        end else begin
          pend_d[r]  = pend_q[r] - 1'b1;
          decCounted = 1'b1;
        end
      end
    end
    inflight_d = inflight_q + TotWidth'(incCounted) - TotWidth'(decCounted);
  end

  // State register with synchronous reset; reset discards all in-flight writes
  // and clears the sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NumRegs; r++) begin
        pend_q[r] <= '0;
      end
      inflight_q     <= '0;
      errOverflow_q  <= 1'b0;
      errUnderflow_q <= 1'b0;
    end else begin
      pend_q         <= pend_d;
      inflight_q     <= inflight_d;
      errOverflow_q  <= errOverflow_d;
      errUnderflow_q <= errUnderflow_d;
    end
  end

  assign inflight      = inflight_q;
  assign err_overflow  = errOverflow_q;
  assign err_underflow = errUnderflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
// Scoreboard bench: the driver computes expected outputs from a per-register
// pending-count model and queues them; a monitor on the falling edge pops and
// compares against the DUT.
module tb_reg_scoreboard;

  localparam int AW     = 5;
  localparam int CW     = 2;
  localparam int NREGS  = 1 << AW;
  localparam int MAXCNT = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs1, rs2, issueRd, wbRd;
  logic          useRs1, useRs2, issueValid, issueWe, wbWe;
  logic          stall, issueFire, errOverflow, errUnderflow;
  logic [AW+CW-1:0] inflight;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          use1;
    logic          use2;
    logic          iv;
    logic          iwe;
    logic [AW-1:0] ird;
    logic          wbwe;
    logic [AW-1:0] wbrd;
  } stim_t;

  typedef struct packed {
    logic        chk;
    logic        stall;
    logic        fire;
    logic [31:0] infl;
    logic        eo;
    logic        eu;
    logic [31:0] cyc;
  } exp_t;

  exp_t expQ[$];
  int   pendM[NREGS];
  bit   eoM, euM;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  reg_scoreboard #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1(rs1), .rs2(rs2), .use_rs1(useRs1), .use_rs2(useRs2),
    .issue_valid(issueValid), .issue_we(issueWe), .issue_rd(issueRd),
    .wb_we(wbWe), .wb_rd(wbRd),
    .stall(stall), .issue_fire(issueFire), .inflight(inflight),
    .err_overflow(errOverflow), .err_underflow(errUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Model stall from the hazard rules, stated over plain integer counts.
  function automatic bit modelStall(stim_t s);
    bit b1, b2, ob;
    b1 = s.use1 && s.rs1 != 0 && pendM[s.rs1] > 0;
    b2 = s.use2 && s.rs2 != 0 && pendM[s.rs2] > 0;
    ob = s.iv && s.iwe && s.ird != 0 && pendM[s.ird] == MAXCNT &&
         !(s.wbwe && s.wbrd == s.ird);
    return b1 || b2 || ob;
  endfunction

  function automatic int modelTotal();
    int t = 0;
    for (int r = 0; r < NREGS; r++) t += pendM[r];
    return t;
  endfunction

  // Advance the model by one clock edge.
  function automatic void modelStep(stim_t s, bit fire);
    bit incOn, decOn;
    if (s.rst) begin
      for (int r = 0; r < NREGS; r++) pendM[r] = 0;
      eoM = 0;
      euM = 0;
      return;
    end
    incOn = fire && s.iwe && s.ird != 0;
    decOn = s.wbwe && s.wbrd != 0;
    if (incOn && decOn && s.ird == s.wbrd) return;
    if (incOn) begin
      if (pendM[s.ird] == MAXCNT) eoM = 1;
      else pendM[s.ird]++;
    end
    if (decOn) begin
      if (pendM[s.wbrd] == 0) euM = 1;
      else pendM[s.wbrd]--;
    end
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, advance the model.
  task automatic applyStimulus(input stim_t s, input bit chk = 1'b1);
    exp_t e;
    bit   st;
    rst = s.rst; rs1 = s.rs1; rs2 = s.rs2; useRs1 = s.use1; useRs2 = s.use2;
    issueValid = s.iv; issueWe = s.iwe; issueRd = s.ird;
    wbWe = s.wbwe; wbRd = s.wbrd;
    st     = modelStall(s);
    e.chk  = chk;
    e.stall = st;
    e.fire = s.iv && !st;
    e.infl = modelTotal();
    e.eo   = eoM;
    e.eu   = euM;
    e.cyc  = cycle;
    expQ.push_back(e);
    @(posedge clk);
    modelStep(s, s.iv && !st);
    cycle++;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req, input int cyc);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  // Monitor: outputs are stable by the falling edge of the cycle they belong to.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        if (e.chk) begin
          checkOutput("stall",     32'(stall),        32'(e.stall), e.cyc);
          checkOutput("fire",      32'(issueFire),    32'(e.fire),  e.cyc);
          checkOutput("inflight",  32'(inflight),     e.infl,       e.cyc);
          checkOutput("overflow",  32'(errOverflow),  32'(e.eo),    e.cyc);
          checkOutput("underflow", 32'(errUnderflow), 32'(e.eu),    e.cyc);
        end
      end
    end
  end

  task automatic doIssue(input int rd, input bit wb = 0, input int wrd = 0);
    stim_t s = idleStim();
    s.iv = 1; s.iwe = 1; s.ird = AW'(rd);
    s.wbwe = wb; s.wbrd = AW'(wrd);
    applyStimulus(s);
  endtask

  task automatic doRetire(input int rd);
    stim_t s = idleStim();
    s.wbwe = 1; s.wbrd = AW'(rd);
    applyStimulus(s);
  endtask

  task automatic doRead(input int r1, input int r2, input bit wb = 0, input int wrd = 0);
    stim_t s = idleStim();
    s.rs1 = AW'(r1); s.rs2 = AW'(r2); s.use1 = 1; s.use2 = 1; s.iv = 1;
    s.wbwe = wb; s.wbrd = AW'(wrd);
    applyStimulus(s);
  endtask

  task automatic doReset();
    stim_t s = idleStim();
    s.rst = 1;
    applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    int    r;
    s = idleStim();
    rst = 0; rs1 = 0; rs2 = 0; useRs1 = 0; useRs2 = 0;
    issueValid = 0; issueWe = 0; issueRd = 0; wbWe = 0; wbRd = 0;
    @(posedge clk);
    #1;
    // First reset cycle: DUT state is undefined until this edge.
    s.rst = 1;
    applyStimulus(s, 1'b0);
    for (int i = 0; i < 4; i++) doRead(i * 7 % NREGS, (i * 11 + 1) % NREGS);

    // Simple RAW on r5, retire three cycles after issue.
    doIssue(5);
    doRead(5, 0);
    doRead(5, 0);
    doRead(5, 0, 1, 5);
    doRead(5, 0);

    // Simultaneous issue and retire to r7.
    doIssue(7);
    doIssue(7, 1, 7);
    doRead(7, 0);
    doRetire(7);
    doRead(7, 0);

    // Saturation of r3, then blocked issue, then issue rescued by a retire.
    doIssue(3); doIssue(3); doIssue(3);
    doIssue(3);
    doIssue(3, 1, 3);
    doRead(0, 3);
    doRetire(3); doRetire(3); doRetire(3);

    // Register 0 is untracked; retire to an idle register is an underflow.
    doIssue(0);
    doRead(0, 0);
    doRetire(0);
    doRetire(9);
    doRead(9, 0);
    doRead(9, 0);

    // Reset while writes are outstanding, then a stale retire.
    doReset();
    doIssue(4); doIssue(4);
    doRead(0, 4);
    doReset();
    doRead(0, 4);
    doRetire(4);
    doRead(4, 4);

    // Randomized traffic over a small register window to provoke hazards.
    doReset();
    for (int i = 0; i < 800; i++) begin
      s = idleStim();
      s.rst  = ($urandom_range(0, 249) == 0);
      s.rs1  = AW'($urandom_range(0, 7));
      s.rs2  = AW'($urandom_range(0, 7));
      s.use1 = $urandom_range(0, 1);
      s.use2 = $urandom_range(0, 1);
      s.iv   = ($urandom_range(0, 3) != 0);
      s.iwe  = ($urandom_range(0, 3) != 0);
      s.ird  = AW'($urandom_range(0, 7));
      r      = $urandom_range(0, 7);
      s.wbrd = AW'(r);
      s.wbwe = (pendM[r] != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
      applyStimulus(s);
    end

    s = idleStim();
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d queued expected 0", expQ.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
